csa_add_sequencer: RTL

Multi-cycle wide-operand add controller that shares one 8-bit carry-skip adder core between two requesters. It arbitrates round-robin and feeds the adder one byte slice per cycle, chaining the carry through a register. It returns an (8*NBYTES)-bit sum with carry-out over a valid/ready response channel. It sits between the requesting datapath logic and the combinational 8-bit carry-skip adder instance.

---
 rtl/csa_add_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/csa_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : csa_add_sequencer
//  Purpose  : Wide-operand add controller. Two requesters share one external
//             8-bit carry-skip adder core. A round-robin arbiter accepts one
//             operation at a time. The operation is then fed to the core one
//             byte slice per cycle, least significant byte first, and the
//             carry is chained through a register. The (8*NBYTES)-bit sum and
//             its carry-out are returned over a valid/ready response channel.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n             clock, asynchronous active-low reset
//    req{0,1}_valid/ready   request handshake per requester
//    req{0,1}_a/_b/_cin     operands and carry-in (sampled at handshake)
//    rsp_valid/rsp_ready    response handshake
//    rsp_sum/cout/id        result, carry out of bit W-1, issuing requester
//    add_a/add_b/add_cin    byte slice driven to the adder core
//    add_sum/add_cout       adder core result (combinational, same cycle)
//    busy                   high while an operation is running or pending
// ============================================================================
module csa_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req1_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_id,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [KW-1:0] c_k_last = KW'(NBYTES - 1);

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_carry;
    logic          r_id;
    logic          r_last;

    logic w_idle;
    logic w_run;
    logic w_done;
    logic w_gnt0;
    logic w_gnt1;
    logic w_accept;

    assign w_idle = (r_state == c_st_idle);
    assign w_run  = (r_state == c_st_run);
    assign w_done = (r_state == c_st_done);

    // Round-robin: on contention the requester not granted last time wins.
    assign w_gnt0 = req0_valid & (~req1_valid | r_last);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);

    // Ready is qualified with rst_n so that it reads 0 for the whole time
    // reset is held, even though IDLE is the reset state.
    assign req0_ready = rst_n & w_idle & w_gnt0;
    assign req1_ready = rst_n & w_idle & w_gnt1;
    assign w_accept   = req0_ready | req1_ready;

    // Operand registers shift right one byte per RUN cycle, so the slice of
    // byte k is always found in bits [7:0]. Likewise the sum register fills
    // from the top: after NBYTES shifts byte 0 sits at the bottom. The carry
    // register is preloaded with cin, so it always holds the carry-in of the
    // current slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_a     <= req1_ready ? req1_a   : req0_a;
                        r_b     <= req1_ready ? req1_b   : req0_b;
                        r_carry <= req1_ready ? req1_cin : req0_cin;
                        r_id    <= req1_ready;
                        r_last  <= req1_ready;
                        r_k     <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_sum   <= {add_sum, r_sum[W-1:8]};
                    r_a     <= r_a >> 8;
                    r_b     <= r_b >> 8;
                    r_carry <= add_cout;
                    r_k     <= r_k + 1'b1;
                    if (r_k == c_k_last) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Response fields only show the registers while DONE; during RUN the
    // sum register holds a partially shifted value that must not leak out.
    assign rsp_valid = w_done;
    assign rsp_sum   = w_done ? r_sum : '0;
    assign rsp_cout  = w_done & r_carry;
    assign rsp_id    = w_done & r_id;

    assign add_a   = w_run ? r_a[7:0] : 8'h00;
    assign add_b   = w_run ? r_b[7:0] : 8'h00;
    assign add_cin = w_run & r_carry;

    assign busy = w_run | w_done;

endmodule
`default_nettype wire
